// File: rtl/icache_rr_arbiter.sv
// Round-robin arbiter that shares one icache bank port among N_CH fetch requesters.
// An in-order ID FIFO routes each bank response back to the channel that issued it.
module icache_rr_arbiter #(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 128,
  parameter int unsigned OUTSTANDING = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_CH-1:0]            ch_req_i,
  input  logic [N_CH*ADDR_WIDTH-1:0] ch_addr_i,
  output logic [N_CH-1:0]            ch_gnt_o,
  output logic [N_CH-1:0]            ch_r_valid_o,
  output logic [DATA_WIDTH-1:0]      ch_r_rdata_o,
  output logic                       m_req_o,
  output logic [ADDR_WIDTH-1:0]      m_addr_o,
  input  logic                       m_gnt_i,
  input  logic                       m_r_valid_i,
  input  logic [DATA_WIDTH-1:0]      m_r_rdata_i,
  output logic                       err_o
);

  localparam int unsigned IdW  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned PtrW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int unsigned CntW = $clog2(OUTSTANDING + 1);

  localparam logic [IdW-1:0]  LastId  = IdW'(N_CH - 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(OUTSTANDING - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(OUTSTANDING);

  logic [IdW-1:0]  prio_q, prio_d;
  logic [IdW-1:0]  fifo_q [OUTSTANDING];
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;

  logic            any_req;
  logic            found;
  logic [IdW-1:0]  winner;
  logic [IdW-1:0]  cand;
  logic [IdW-1:0]  head;
  int unsigned     idx;
  logic            push;
  logic            pop;

  // Scan channels starting at prio, wrapping at N_CH-1; first requester wins.
  always_comb begin
    any_req = |ch_req_i;
    found   = 1'b0;
    winner  = '0;
    idx     = 0;
    cand    = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      idx = prio_q + i;
      if (idx >= N_CH) begin
        idx = idx - N_CH;
      end
      cand = IdW'(idx);
      if (!found && ch_req_i[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // Full FIFO blocks new requests even when a pop happens in the same cycle.
  assign m_req_o = any_req && (cnt_q != FullCnt);
  assign push    = m_req_o && m_gnt_i;
  assign pop     = m_r_valid_i && (cnt_q != '0);
  assign head    = fifo_q[rd_ptr_q];

  always_comb begin
    m_addr_o     = '0;
    ch_gnt_o     = '0;
    ch_r_valid_o = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (any_req && (winner == IdW'(k))) begin
        m_addr_o = ch_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
      end
      ch_gnt_o[k]     = push && (winner == IdW'(k));
      ch_r_valid_o[k] = pop && (head == IdW'(k));
    end
  end

  assign ch_r_rdata_o = m_r_rdata_i;
  assign err_o        = err_q;

  always_comb begin
    prio_d   = prio_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    if (push) begin
      prio_d   = (winner == LastId) ? '0 : winner + 1'b1;
      wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
    end
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    // A response with nothing outstanding is a protocol error; sticky until reset.
    if (m_r_valid_i && (cnt_q == '0)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q   <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      for (int unsigned j = 0; j < OUTSTANDING; j++) begin
        fifo_q[j] <= '0;
      end
    end else begin
      prio_q   <= prio_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      if (push) begin
        fifo_q[wr_ptr_q] <= winner;
      end
    end
  end

endmodule

// File: tb/tb_icache_rr_arbiter.sv
// Directed bench for icache_rr_arbiter: a cycle-vector table on a 4-channel instance plus
// hand sequences for mid-operation reset and a 3-channel priority wrap.
module tb_icache_rr_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 128;

  logic          clk;
  logic          rst_n;

  logic [3:0]    ch_req;
  logic [4*AW-1:0] ch_addr;
  logic [3:0]    ch_gnt;
  logic [3:0]    ch_r_valid;
  logic [DW-1:0] ch_r_rdata;
  logic          m_req;
  logic [AW-1:0] m_addr;
  logic          m_gnt;
  logic          m_r_valid;
  logic [DW-1:0] m_r_rdata;
  logic          err;

  logic [2:0]    ch_req3;
  logic [3*AW-1:0] ch_addr3;
  logic [2:0]    ch_gnt3;
  logic [2:0]    ch_r_valid3;
  logic [DW-1:0] ch_r_rdata3;
  logic          m_req3;
  logic [AW-1:0] m_addr3;
  logic          m_gnt3;
  logic          m_r_valid3;
  logic [DW-1:0] m_r_rdata3;
  logic          err3;

  int n_cmp;
  int n_fail;

  function automatic logic [AW-1:0] addr_of(input int k);
    if (k < 0) return '0;
    return 32'h1000_0000 + 32'(k) * 32'h0000_0104;
  endfunction

  assign ch_addr  = {addr_of(3), addr_of(2), addr_of(1), addr_of(0)};
  assign ch_addr3 = {addr_of(2), addr_of(1), addr_of(0)};

  icache_rr_arbiter #(
    .N_CH(4), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUTSTANDING(2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ch_req_i     (ch_req),
    .ch_addr_i    (ch_addr),
    .ch_gnt_o     (ch_gnt),
    .ch_r_valid_o (ch_r_valid),
    .ch_r_rdata_o (ch_r_rdata),
    .m_req_o      (m_req),
    .m_addr_o     (m_addr),
    .m_gnt_i      (m_gnt),
    .m_r_valid_i  (m_r_valid),
    .m_r_rdata_i  (m_r_rdata),
    .err_o        (err)
  );

  icache_rr_arbiter #(
    .N_CH(3), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUTSTANDING(2)
  ) dut3 (
    .clk          (clk),
    .rst_n        (rst_n),
    .ch_req_i     (ch_req3),
    .ch_addr_i    (ch_addr3),
    .ch_gnt_o     (ch_gnt3),
    .ch_r_valid_o (ch_r_valid3),
    .ch_r_rdata_o (ch_r_rdata3),
    .m_req_o      (m_req3),
    .m_addr_o     (m_addr3),
    .m_gnt_i      (m_gnt3),
    .m_r_valid_i  (m_r_valid3),
    .m_r_rdata_i  (m_r_rdata3),
    .err_o        (err3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic       gnt;
    logic       rv;
    logic       e_mreq;
    logic [3:0] e_gnt;
    logic [3:0] e_rv;
    logic       e_err;
    int         e_win;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [3:0] req, input logic gnt, input logic rv,
                              input logic e_mreq, input logic [3:0] e_gnt,
                              input logic [3:0] e_rv, input logic e_err, input int e_win);
    vec_t v;
    v.req = req; v.gnt = gnt; v.rv = rv;
    v.e_mreq = e_mreq; v.e_gnt = e_gnt; v.e_rv = e_rv; v.e_err = e_err; v.e_win = e_win;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    ch_req = '0; m_gnt = 1'b0; m_r_valid = 1'b0; m_r_rdata = '0;
    ch_req3 = '0; m_gnt3 = 1'b0; m_r_valid3 = 1'b0; m_r_rdata3 = '0;

    // Idle, rotation, sparse/wrap, backpressure, outstanding limit, drop, spurious.
    for (int i = 0; i < 3; i++) vecs.push_back(mk(4'h0, 0, 0, 0, 4'h0, 4'h0, 0, -1));
    vecs.push_back(mk(4'hF, 1, 0, 1, 4'h1, 4'h0, 0, 0));
    vecs.push_back(mk(4'hF, 1, 1, 1, 4'h2, 4'h1, 0, 1));
    vecs.push_back(mk(4'hF, 1, 1, 1, 4'h4, 4'h2, 0, 2));
    vecs.push_back(mk(4'hF, 1, 1, 1, 4'h8, 4'h4, 0, 3));
    vecs.push_back(mk(4'hF, 1, 1, 1, 4'h1, 4'h8, 0, 0));
    vecs.push_back(mk(4'h0, 0, 1, 0, 4'h0, 4'h1, 0, -1));
    vecs.push_back(mk(4'h4, 1, 0, 1, 4'h4, 4'h0, 0, 2));
    vecs.push_back(mk(4'h5, 1, 1, 1, 4'h1, 4'h4, 0, 0));
    vecs.push_back(mk(4'h5, 1, 1, 1, 4'h4, 4'h1, 0, 2));
    vecs.push_back(mk(4'h0, 0, 1, 0, 4'h0, 4'h4, 0, -1));
    for (int i = 0; i < 5; i++) vecs.push_back(mk(4'h2, 0, 0, 1, 4'h0, 4'h0, 0, 1));
    vecs.push_back(mk(4'h2, 1, 0, 1, 4'h2, 4'h0, 0, 1));
    vecs.push_back(mk(4'h0, 0, 1, 0, 4'h0, 4'h2, 0, -1));
    vecs.push_back(mk(4'hF, 0, 0, 1, 4'h0, 4'h0, 0, 2));
    vecs.push_back(mk(4'hF, 1, 0, 1, 4'h4, 4'h0, 0, 2));
    vecs.push_back(mk(4'hF, 1, 0, 1, 4'h8, 4'h0, 0, 3));
    vecs.push_back(mk(4'hF, 1, 0, 0, 4'h0, 4'h0, 0, 0));
    vecs.push_back(mk(4'hF, 1, 1, 0, 4'h0, 4'h4, 0, 0));
    vecs.push_back(mk(4'hF, 1, 0, 1, 4'h1, 4'h0, 0, 0));
    vecs.push_back(mk(4'h0, 0, 1, 0, 4'h0, 4'h8, 0, -1));
    vecs.push_back(mk(4'h0, 0, 1, 0, 4'h0, 4'h1, 0, -1));
    vecs.push_back(mk(4'h2, 0, 0, 1, 4'h0, 4'h0, 0, 1));
    vecs.push_back(mk(4'h4, 1, 0, 1, 4'h4, 4'h0, 0, 2));
    vecs.push_back(mk(4'h0, 0, 1, 0, 4'h0, 4'h4, 0, -1));
    vecs.push_back(mk(4'h0, 0, 1, 0, 4'h0, 4'h0, 0, -1));
    vecs.push_back(mk(4'h0, 0, 0, 0, 4'h0, 4'h0, 1, -1));
    vecs.push_back(mk(4'h2, 1, 0, 1, 4'h2, 4'h0, 1, 1));

    // Outputs during reset.
    #12;
    chk("rst.mreq", m_req, 0);
    chk("rst.gnt", ch_gnt, 0);
    chk("rst.rvalid", ch_r_valid, 0);
    chk("rst.err", err, 0);
    chk("rst.addr", m_addr, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < vecs.size(); i++) begin
      ch_req    = vecs[i].req;
      m_gnt     = vecs[i].gnt;
      m_r_valid = vecs[i].rv;
      m_r_rdata = {4{32'(i) ^ 32'h5A5A_0000}};
      @(negedge clk);
      chk($sformatf("v%0d.mreq", i), m_req, vecs[i].e_mreq);
      chk($sformatf("v%0d.gnt", i), ch_gnt, vecs[i].e_gnt);
      chk($sformatf("v%0d.rvalid", i), ch_r_valid, vecs[i].e_rv);
      chk($sformatf("v%0d.err", i), err, vecs[i].e_err);
      chk($sformatf("v%0d.addr", i), m_addr, addr_of(vecs[i].e_win));
      chk($sformatf("v%0d.rdata", i), ch_r_rdata, {4{32'(i) ^ 32'h5A5A_0000}});
      @(posedge clk);
      #1;
    end

    // Mid-operation reset: one ID in flight, prio=2, err set.
    ch_req = '0; m_gnt = 1'b0; m_r_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst.err", err, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ch_req = 4'hF;
    @(negedge clk);
    chk("midrst.prio_addr", m_addr, addr_of(0));
    chk("midrst.mreq", m_req, 1);
    tick();
    ch_req = '0; m_r_valid = 1'b1;
    @(negedge clk);
    chk("midrst.late_rvalid", ch_r_valid, 0);
    tick();
    m_r_valid = 1'b0;
    @(negedge clk);
    chk("midrst.late_err", err, 1);
    tick();
    chk("midrst.err_sticky", err, 1);

    // 3-channel wrap: channel 2 wins, prio wraps to 0.
    ch_req3 = 3'b100; m_gnt3 = 1'b1;
    @(negedge clk);
    chk("n3.c0.gnt", ch_gnt3, 3'b100);
    chk("n3.c0.addr", m_addr3, addr_of(2));
    tick();
    ch_req3 = 3'b111; m_r_valid3 = 1'b1; m_r_rdata3 = {4{32'hCAFE_0003}};
    @(negedge clk);
    chk("n3.c1.gnt", ch_gnt3, 3'b001);
    chk("n3.c1.addr", m_addr3, addr_of(0));
    chk("n3.c1.rvalid", ch_r_valid3, 3'b100);
    chk("n3.c1.rdata", ch_r_rdata3, {4{32'hCAFE_0003}});
    tick();
    ch_req3 = 3'b110;
    @(negedge clk);
    chk("n3.c2.gnt", ch_gnt3, 3'b010);
    chk("n3.c2.rvalid", ch_r_valid3, 3'b001);
    tick();
    ch_req3 = '0; m_gnt3 = 1'b0;
    @(negedge clk);
    chk("n3.c3.rvalid", ch_r_valid3, 3'b010);
    chk("n3.c3.err", err3, 0);
    tick();
    m_r_valid3 = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/icache_rr_arbiter.md
# icache_rr_arbiter

N-to-1 round-robin arbiter sharing one instruction-cache SCM bank port among `N_CH` fetch requesters. It sits in the icache interconnect between the per-core fetch ports and a bank, and selects one request per cycle with rotating priority. Priority advances only on an accepted transfer (req & gnt), which keeps switching activity low when traffic is idle. An in-order ID FIFO routes each read response back to the channel that issued it.

## Interface
- `N_CH`, 4: number of requesting channels, ≥2, need not be a power of two.
- `ADDR_WIDTH`, 32: request address width.
- `DATA_WIDTH`, 128: response data width.
- `OUTSTANDING`, 2: maximum accepted-but-unanswered requests (ID FIFO depth), ≥1.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `ch_req_i`  in  N_CH  per-channel request.
- `ch_addr_i`  in  N_CH*ADDR_WIDTH  per-channel address; channel k occupies bits [k*ADDR_WIDTH +: ADDR_WIDTH].
- `ch_gnt_o`  out  N_CH  per-channel grant, one-hot or zero.
- `ch_r_valid_o`  out  N_CH  per-channel response valid, one-hot or zero.
- `ch_r_rdata_o`  out  DATA_WIDTH  response data, broadcast to all channels.
- `m_req_o`  out  1  request to the bank.
- `m_addr_o`  out  ADDR_WIDTH  address of the winning channel.
- `m_gnt_i`  in  1  bank grant.
- `m_r_valid_i`  in  1  bank response valid.
- `m_r_rdata_i`  in  DATA_WIDTH  bank response data.
- `err_o`  out  1  sticky protocol error flag.

## Operation
- **State:**
  - priority pointer `prio` (width clog2(N_CH)), reset 0;
  - ID FIFO holding `OUTSTANDING` entries of clog2(N_CH) bits, with read pointer, write pointer and occupancy `cnt` (0..OUTSTANDING), all reset 0;
  - `err` register, reset 0.
- **Winner selection:** the winner is the first channel with `ch_req_i` asserted, scanning `prio`, `prio+1`, … and wrapping from N_CH-1 to 0. Selection is purely combinational.
- **Full gating:**
  - `m_req_o = (|ch_req_i) & (cnt != OUTSTANDING)`.
  - When the FIFO is full, `m_req_o` is 0 even if a pop occurs in the same cycle. There is no combinational path from `m_r_valid_i` to `m_req_o`.
- **Address and grant:**
  - `m_addr_o` carries the winner's address whenever any request is present; otherwise it is 0.
  - `ch_gnt_o[winner] = m_req_o & m_gnt_i`; all other bits are 0.
- **Transfer** (`m_req_o & m_gnt_i`):
  - push the winner ID into the FIFO;
  - set `prio <= winner+1`, wrapping to 0 when the winner is N_CH-1.
  - With no transfer, `prio` holds.
- **Response** (`m_r_valid_i` with `cnt != 0`):
  - `ch_r_valid_o[fifo_head] = 1`;
  - pop the FIFO;
  - `ch_r_rdata_o = m_r_rdata_i` unconditionally.
- **Push and pop in the same cycle:** `cnt` is unchanged and both pointers advance. Pointers wrap at OUTSTANDING-1.
- **Spurious response** (`m_r_valid_i` with `cnt == 0`):
  - `ch_r_valid_o` stays all-zero;
  - no pop occurs;
  - `err_o` is set and remains 1 until reset.
- **Channel protocol:** a channel holds req and addr until granted. If a channel drops req before grant, the next cycle re-selects among the remaining requests with no penalty and no change to `prio`.
- **Reset values:**
  - `ch_gnt_o`, `ch_r_valid_o`, `m_req_o`, `err_o` = 0;
  - `m_addr_o` = 0 (no request present).
- **Reset mid-operation:** in-flight IDs are discarded and responses arriving afterwards raise `err_o`. The system resets bank and arbiter together.

## Timing
- Grant latency: 0 cycles. `ch_gnt_o` is combinational from `ch_req_i`, `m_gnt_i`, `prio` and `cnt`.
- Response routing latency: 0 cycles. `ch_r_valid_o` is combinational from `m_r_valid_i` and the FIFO head.
- `prio`, the FIFO and `err` update on the rising `clk` edge following the qualifying cycle.
- Throughput: one transfer per cycle while `cnt < OUTSTANDING`. With `OUTSTANDING=1` and a 1-cycle bank, transfers occur every other cycle at most.
- Fairness: with all N_CH channels continuously requesting and `m_gnt_i=1`, each channel is granted exactly once in every N_CH consecutive transfers.

## Test plan
- **Reset then idle:** hold `ch_req_i=0` for 10 cycles -> all outputs 0, `prio` stays 0, no error.
- **All-request rotation:** N_CH=4, `ch_req_i=4'b1111`, `m_gnt_i=1`, bank answers 1 cycle later -> grant order 0,1,2,3,0,…; each `ch_r_valid_o` pulse matches the channel granted one cycle earlier.
- **Sparse and wrap:**
  - from `prio=3`, `ch_req_i=4'b0101` -> channel 0 wins and `prio` becomes 1;
  - next cycle -> channel 2 wins and `prio` becomes 3;
  - N_CH=3 variant: a win by channel 2 wraps `prio` to 0.
- **Backpressure:** `m_gnt_i=0` for 5 cycles with `ch_req_i=4'b0010` -> `m_req_o=1`, no grant, `prio` unchanged. Releasing `m_gnt_i` -> exactly one `ch_gnt_o[1]` pulse.
- **Outstanding limit:** OUTSTANDING=2, two grants with no responses -> `m_req_o` drops to 0 while requests stay pending. One `m_r_valid_i` in the same cycle still leaves `m_req_o=0`; the next cycle it returns to 1.
- **Spurious response:** `m_r_valid_i=1` with an empty FIFO -> `ch_r_valid_o=0` and `err_o` goes to 1 and stays 1. Only an `rst_n` pulse clears it; the pulse also clears `prio` and `cnt` asynchronously.
